// File: rtl/clk_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_gen_pkg                                                          |
// | Shared types, defaults and helpers for the clk_div_gen divider tree. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package clk_gen_pkg;

  typedef enum logic [0:0] {
    S_ACQ    = 1'b0,
    S_LOCKED = 1'b1
  } lock_state_t;

  localparam int c_def_n_out      = 3;
  localparam int c_def_base_log2  = 3;
  localparam int c_def_lock_wraps = 1;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_edge                                                         |
// | Registered rise/fall strobe for one divided-clock bit.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clk_div_edge (
  input  logic clk_32f,
  input  logic reset,
  input  logic sync,
  input  logic en,
  input  logic cur_bit,
  input  logic nxt_bit,
  output logic rise_stb,
  output logic fall_stb
);

  // Resync forces the bit to 0, so only a falling edge can be produced.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else if (sync) begin
      rise_stb <= 1'b0;
      fall_stb <= cur_bit;
    end else if (en) begin
      rise_stb <= ~cur_bit & nxt_bit;
      fall_stb <= cur_bit & ~nxt_bit;
    end else begin
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_gen                                                          |
// | Power-of-two clock divider with edge strobes, resync and lock flag.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module clk_div_gen
  import clk_gen_pkg::*;
#(
  parameter int N_OUT      = c_def_n_out,
  parameter int BASE_LOG2  = c_def_base_log2,
  parameter int LOCK_WRAPS = c_def_lock_wraps
) (
  input  logic                       clk_32f,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       sync,
  output logic [N_OUT-1:0]           clk_out,
  output logic [N_OUT-1:0]           rise_stb,
  output logic [N_OUT-1:0]           fall_stb,
  output logic                       wrap_stb,
  output logic [BASE_LOG2+N_OUT-2:0] phase,
  output logic                       locked
);

  localparam int c_cw  = BASE_LOG2 + N_OUT - 1;
  localparam int c_lcw = clog2(LOCK_WRAPS + 1);
  localparam logic [c_lcw-1:0] c_lock_target = c_lcw'(LOCK_WRAPS);

  generate
    if (N_OUT < 1 || BASE_LOG2 < 1 || LOCK_WRAPS < 1) begin : g_bad_params
      $error("clk_div_gen: N_OUT, BASE_LOG2 and LOCK_WRAPS must all be >= 1");
    end
  endgenerate

  logic [c_cw-1:0]  r_cnt;
  logic [c_cw-1:0]  w_cnt_n;
  logic             w_at_top;
  lock_state_t      r_state;
  logic [c_lcw-1:0] r_lock_cnt;
  logic [c_lcw-1:0] w_lock_inc;

  assign w_cnt_n    = r_cnt + 1'b1;
  assign w_at_top   = &r_cnt;
  assign w_lock_inc = (r_lock_cnt == c_lock_target) ? r_lock_cnt : r_lock_cnt + 1'b1;

  always_ff @(posedge clk_32f) begin
    if (!reset || sync) begin
      r_cnt    <= '0;
      wrap_stb <= 1'b0;
    end else if (en) begin
      r_cnt    <= w_cnt_n;
      wrap_stb <= w_at_top;
    end else begin
      wrap_stb <= 1'b0;
    end
  end

  // Only wraps taken while advancing count toward lock; a resync discards them.
  always_ff @(posedge clk_32f) begin
    if (!reset || sync) begin
      r_state    <= S_ACQ;
      r_lock_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      case (r_state)
        S_ACQ: begin
          if (en && w_at_top) begin
            r_lock_cnt <= w_lock_inc;
            if (w_lock_inc == c_lock_target) begin
              r_state <= S_LOCKED;
              locked  <= 1'b1;
            end
          end
        end
        S_LOCKED: begin
          locked <= 1'b1;
        end
        default: begin
          r_state <= S_ACQ;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  assign clk_out = r_cnt[c_cw-1:BASE_LOG2-1];
  assign phase   = r_cnt;

  generate
    for (genvar i = 0; i < N_OUT; i++) begin : g_edge
      clk_div_edge u_edge (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .sync     (sync),
        .en       (en),
        .cur_bit  (r_cnt[BASE_LOG2-1+i]),
        .nxt_bit  (w_cnt_n[BASE_LOG2-1+i]),
        .rise_stb (rise_stb[i]),
        .fall_stb (fall_stb[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clk_div_gen                                                       |
// | Directed and randomized checks of four clk_div_gen configurations.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_clk_div_gen;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;
  logic en      = 1'b0;
  logic sync    = 1'b0;

  always #5 clk_32f = ~clk_32f;

  // Instances: 0 defaults, 1 defaults with 3 lock wraps, 2 N=1/B=1, 3 N=4/B=2.
  logic [2:0] co0, rs0, fs0, co1, rs1, fs1;
  logic [4:0] ph0, ph1, ph3;
  logic [0:0] co2, rs2, fs2, ph2;
  logic [3:0] co3, rs3, fs3;
  logic ws0, lk0, ws1, lk1, ws2, lk2, ws3, lk3;

  clk_div_gen #(.N_OUT(3), .BASE_LOG2(3), .LOCK_WRAPS(1)) dut0 (
    .clk_32f(clk_32f), .reset(reset), .en(en), .sync(sync), .clk_out(co0),
    .rise_stb(rs0), .fall_stb(fs0), .wrap_stb(ws0), .phase(ph0), .locked(lk0));
  clk_div_gen #(.N_OUT(3), .BASE_LOG2(3), .LOCK_WRAPS(3)) dut1 (
    .clk_32f(clk_32f), .reset(reset), .en(en), .sync(sync), .clk_out(co1),
    .rise_stb(rs1), .fall_stb(fs1), .wrap_stb(ws1), .phase(ph1), .locked(lk1));
  clk_div_gen #(.N_OUT(1), .BASE_LOG2(1), .LOCK_WRAPS(1)) dut2 (
    .clk_32f(clk_32f), .reset(reset), .en(en), .sync(sync), .clk_out(co2),
    .rise_stb(rs2), .fall_stb(fs2), .wrap_stb(ws2), .phase(ph2), .locked(lk2));
  clk_div_gen #(.N_OUT(4), .BASE_LOG2(2), .LOCK_WRAPS(2)) dut3 (
    .clk_32f(clk_32f), .reset(reset), .en(en), .sync(sync), .clk_out(co3),
    .rise_stb(rs3), .fall_stb(fs3), .wrap_stb(ws3), .phase(ph3), .locked(lk3));

  logic [31:0] obs_ph [4];
  logic [31:0] obs_co [4];
  logic [31:0] obs_rs [4];
  logic [31:0] obs_fs [4];
  logic        obs_ws [4];
  logic        obs_lk [4];

  assign obs_ph[0] = 32'(ph0); assign obs_co[0] = 32'(co0); assign obs_rs[0] = 32'(rs0);
  assign obs_fs[0] = 32'(fs0); assign obs_ws[0] = ws0;      assign obs_lk[0] = lk0;
  assign obs_ph[1] = 32'(ph1); assign obs_co[1] = 32'(co1); assign obs_rs[1] = 32'(rs1);
  assign obs_fs[1] = 32'(fs1); assign obs_ws[1] = ws1;      assign obs_lk[1] = lk1;
  assign obs_ph[2] = 32'(ph2); assign obs_co[2] = 32'(co2); assign obs_rs[2] = 32'(rs2);
  assign obs_fs[2] = 32'(fs2); assign obs_ws[2] = ws2;      assign obs_lk[2] = lk2;
  assign obs_ph[3] = 32'(ph3); assign obs_co[3] = 32'(co3); assign obs_rs[3] = 32'(rs3);
  assign obs_fs[3] = 32'(fs3); assign obs_ws[3] = ws3;      assign obs_lk[3] = lk3;

  // Reference model: phase as an integer, outputs derived arithmetically.
  int p_n [4] = '{3, 3, 1, 4};
  int p_b [4] = '{3, 3, 1, 2};
  int p_l [4] = '{1, 3, 1, 2};
  int m_phase [4] = '{0, 0, 0, 0};
  int m_wraps [4] = '{0, 0, 0, 0};
  int m_locked[4] = '{0, 0, 0, 0};
  int m_rise  [4] = '{0, 0, 0, 0};
  int m_fall  [4] = '{0, 0, 0, 0};
  int m_wrap  [4] = '{0, 0, 0, 0};

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic int outs_of(input int d, input int ph);
    return (ph >> (p_b[d] - 1)) & ((1 << p_n[d]) - 1);
  endfunction

  task automatic model_step();
    int modulus, cur, nph, nxt;
    for (int d = 0; d < 4; d++) begin
      modulus = 1 << (p_b[d] + p_n[d] - 1);
      cur     = outs_of(d, m_phase[d]);
      if (!reset) begin
        m_phase[d] = 0; m_rise[d] = 0; m_fall[d] = 0; m_wrap[d] = 0;
        m_locked[d] = 0; m_wraps[d] = 0;
      end else if (sync) begin
        m_fall[d] = cur; m_rise[d] = 0; m_wrap[d] = 0;
        m_phase[d] = 0; m_locked[d] = 0; m_wraps[d] = 0;
      end else if (en) begin
        nph       = (m_phase[d] + 1) % modulus;
        nxt       = outs_of(d, nph);
        m_rise[d] = ~cur & nxt;
        m_fall[d] = cur & ~nxt;
        m_wrap[d] = (m_phase[d] == modulus - 1) ? 1 : 0;
        if (m_wrap[d] == 1 && m_locked[d] == 0) begin
          m_wraps[d]++;
          if (m_wraps[d] >= p_l[d]) m_locked[d] = 1;
        end
        m_phase[d] = nph;
      end else begin
        m_rise[d] = 0; m_fall[d] = 0; m_wrap[d] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_32f);
    model_step();
    #1;
  endtask

  task automatic do_reset_release();
    reset = 1'b0; sync = 1'b0; en = 1'b0;
    tick(); tick();
    reset = 1'b1; en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; sync = 1'b0;
    tick(); tick(); tick();
    for (int d = 0; d < 4; d++) begin
      tests_run++;
      if ({obs_ph[d], obs_co[d], obs_rs[d], obs_fs[d], obs_ws[d], obs_lk[d]} !== 130'd0) begin
        tests_failed++;
        $display("FAIL reset dut%0d: phase=%0d clk=%0h rise=%0h fall=%0h wrap=%b lock=%b, required all 0",
                 d, obs_ph[d], obs_co[d], obs_rs[d], obs_fs[d], obs_ws[d], obs_lk[d]);
      end
    end
  endtask

  task automatic test_count_lock();
    do_reset_release();
    for (int k = 1; k <= 96; k++) begin
      tick();
      tests_run++;
      if (obs_ph[0] !== 32'(k % 32) || obs_rs[0][0] !== (k % 8 == 4) ||
          obs_fs[0][0] !== (k % 8 == 0) || obs_lk[0] !== (k >= 32) || obs_lk[1] !== (k >= 96)) begin
        tests_failed++;
        $display("FAIL count edge %0d: phase=%0d rise0=%b fall0=%b lock0=%b lock1=%b, required %0d %b %b %b %b",
                 k, obs_ph[0], obs_rs[0][0], obs_fs[0][0], obs_lk[0], obs_lk[1],
                 k % 32, k % 8 == 4, k % 8 == 0, k >= 32, k >= 96);
      end
      if (k == 16) begin
        tests_run++;
        if (obs_co[0][2] !== 1'b1 || obs_rs[0][2] !== 1'b1) begin
          tests_failed++;
          $display("FAIL clk2_rise edge 16: clk2=%b rise2=%b, required 1 1", obs_co[0][2], obs_rs[0][2]);
        end
      end
      if (k == 32) begin
        tests_run++;
        if (obs_ws[0] !== 1'b1 || obs_fs[0] !== 32'h7 || obs_co[0] !== 32'h0) begin
          tests_failed++;
          $display("FAIL wrap edge 32: wrap=%b fall=%0h clk=%0h, required 1 7 0", obs_ws[0], obs_fs[0], obs_co[0]);
        end
      end
    end
  endtask

  task automatic test_hold();
    do_reset_release();
    for (int k = 1; k <= 21; k++) begin
      en = (k >= 10 && k <= 14) ? 1'b0 : 1'b1;
      tick();
      if (k >= 10 && k <= 14) begin
        tests_run++;
        if (obs_ph[0] !== 32'd9 || obs_rs[0] !== 32'd0 || obs_fs[0] !== 32'd0 ||
            obs_co[0] !== 32'h2 || obs_ws[0] !== 1'b0) begin
          tests_failed++;
          $display("FAIL hold edge %0d: phase=%0d rise=%0h fall=%0h clk=%0h, required 9 0 0 2",
                   k, obs_ph[0], obs_rs[0], obs_fs[0], obs_co[0]);
        end
      end else if (k >= 15) begin
        tests_run++;
        if (obs_ph[0] !== 32'(k - 5) || obs_rs[0][2] !== (k == 21)) begin
          tests_failed++;
          $display("FAIL resume edge %0d: phase=%0d rise2=%b, required %0d %b",
                   k, obs_ph[0], obs_rs[0][2], k - 5, k == 21);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_resync();
    do_reset_release();
    for (int k = 1; k <= 51; k++) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tests_run++;
    if (obs_ph[0] !== 32'd0 || obs_fs[0] !== 32'h4 || obs_rs[0] !== 32'd0 ||
        obs_ws[0] !== 1'b0 || obs_lk[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL resync: phase=%0d fall=%0h rise=%0h wrap=%b lock=%b, required 0 4 0 0 0",
               obs_ph[0], obs_fs[0], obs_rs[0], obs_ws[0], obs_lk[0]);
    end
    for (int k = 53; k <= 84; k++) begin
      tick();
      tests_run++;
      if (obs_lk[0] !== (k >= 84)) begin
        tests_failed++;
        $display("FAIL relock edge %0d: lock=%b, required %b", k, obs_lk[0], k >= 84);
      end
    end
  endtask

  task automatic test_reset_priority();
    do_reset_release();
    for (int k = 1; k <= 45; k++) tick();
    reset = 1'b0; sync = 1'b1;
    tick();
    tests_run++;
    if (obs_ph[0] !== 32'd0 || obs_co[0] !== 32'd0 || obs_fs[0] !== 32'd0 ||
        obs_rs[0] !== 32'd0 || obs_lk[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_prio: phase=%0d clk=%0h fall=%0h rise=%0h lock=%b, required all 0",
               obs_ph[0], obs_co[0], obs_fs[0], obs_rs[0], obs_lk[0]);
    end
    reset = 1'b1; sync = 1'b0;
    tick();
    tests_run++;
    if (obs_ph[0] !== 32'd1) begin
      tests_failed++;
      $display("FAIL reset_release: phase=%0d, required 1", obs_ph[0]);
    end
  endtask

  task automatic test_param_sweep();
    do_reset_release();
    for (int k = 1; k <= 40; k++) begin
      tick();
      tests_run++;
      if (obs_co[2] !== 32'(k % 2) || obs_rs[2] !== 32'(k % 2) || obs_fs[2] !== 32'((k + 1) % 2) ||
          obs_co[3] !== 32'((k % 32) >> 1)) begin
        tests_failed++;
        $display("FAIL sweep edge %0d: clk2=%0h rise2=%0h fall2=%0h clk3=%0h, required %0h %0h %0h %0h",
                 k, obs_co[2], obs_rs[2], obs_fs[2], obs_co[3], k % 2, k % 2, (k + 1) % 2, (k % 32) >> 1);
      end
    end
  endtask

  task automatic test_random();
    do_reset_release();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) < 2)  ? 1'b0 : 1'b1;
      sync  = ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0;
      en    = ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0;
      tick();
      for (int d = 0; d < 4; d++) begin
        tests_run++;
        if (obs_ph[d] !== 32'(m_phase[d]) || obs_co[d] !== 32'(outs_of(d, m_phase[d])) ||
            obs_rs[d] !== 32'(m_rise[d]) || obs_fs[d] !== 32'(m_fall[d]) ||
            obs_ws[d] !== (m_wrap[d] != 0) || obs_lk[d] !== (m_locked[d] != 0)) begin
          tests_failed++;
          $display("FAIL random c%0d dut%0d: ph=%0d clk=%0h r=%0h f=%0h w=%b l=%b, required ph=%0d clk=%0h r=%0h f=%0h w=%0d l=%0d",
                   c, d, obs_ph[d], obs_co[d], obs_rs[d], obs_fs[d], obs_ws[d], obs_lk[d],
                   m_phase[d], outs_of(d, m_phase[d]), m_rise[d], m_fall[d], m_wrap[d], m_locked[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_lock();
    test_hold();
    test_resync();
    test_reset_priority();
    test_param_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
